riscv_zero_fetch: RTL
=====================

Name: riscv_zero_fetch

Overview:
- Instruction fetch stage for riscv_zero.
- Generates PCs and issues in-order requests to instruction memory.
- Buffers returned instruction words in a small FIFO and presents them, with their PC, to the decode stage through a valid/ready handshake.
- Accepts branch/jump redirects from execute: flushes the buffer and discards stale in-flight responses.

Parameters:
- RESET_PC, 64'h0, PC of the first fetch after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2.
- CNT_W, 2, width of the occupancy and in-flight counters; must hold values 0..FIFO_DEPTH.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  64  fetch address (word aligned).
- imem_resp_valid  input  1  response word valid; in order; no backpressure.
- imem_resp_data  input  32  instruction word.
- redirect_valid  input  1  execute redirect strobe.
- redirect_pc  input  64  redirect target.
- inst_valid  output  1  buffer head valid to decode.
- inst_ready  input  1  decode consumes the head this cycle.
- inst_data  output  32  head instruction; 32'h00000013 (NOP) when inst_valid=0.
- pc_out  output  64  PC of the head instruction; 0 when inst_valid=0.

Behaviour:
- Reset (asynchronous, active-high) clears state immediately:
  - pc_q=RESET_PC.
  - FIFO count, rd_ptr and wr_ptr = 0.
  - inflight=0, drop=0.
  - imem_req_valid=0, inst_valid=0, inst_data=NOP, pc_out=0.
  - Reset asserted mid-operation abandons all in-flight requests. Any response after reset deasserts while inflight=0 is ignored.
- Request issue:
  - imem_req_valid = !reset && (count + inflight < FIFO_DEPTH) && !redirect_valid.
  - imem_req_addr = pc_q.
  - This guarantees buffer space for every outstanding response.
  - Request accepted (valid && ready): pc_q += 4 (64-bit wrap-around allowed), inflight += 1.
- Response:
  - On imem_resp_valid, inflight -= 1.
  - If drop>0: drop -= 1 and the word is discarded.
  - Otherwise the word and its PC are written into the FIFO at wr_ptr. The PC comes from a second register, resp_pc_q, which advances by 4 on each non-dropped response.
  - imem_resp_valid while inflight=0 is a protocol error; ignore it and leave the counters unchanged.
- Output:
  - The FIFO is registered. A word written in cycle N is visible on inst_valid/inst_data/pc_out in cycle N+1, at the earliest.
  - Minimum latency from request acceptance to inst_valid is 2 cycles with a 1-cycle memory.
  - Pop occurs on inst_valid && inst_ready.
  - Simultaneous push and pop is allowed at any count. A push while full cannot occur by construction; assert in simulation.
  - Pop while empty is ignored.
- Redirect (redirect_valid=1 in cycle N); takes priority over everything else that cycle:
  - pc_q and resp_pc_q are set to {redirect_pc[63:2], 2'b00}.
  - The FIFO is flushed: count, rd_ptr and wr_ptr = 0.
  - drop is set to the number of requests outstanding after cycle N. That is inflight, minus 1 if a response arrives in cycle N, plus 1 if a request is accepted in cycle N. No request is accepted in cycle N because imem_req_valid is gated.
  - A response arriving in cycle N is discarded.
  - An output handshake in cycle N completes normally for decode (decode owns squashing); the flush still applies.
  - A second redirect while drop>0 recomputes drop by the same rule.
  - The first request to the new PC is issued in cycle N+1.
- Counters saturate only by construction. No counter shall wrap.

Test Plan:
- Reset release, RESET_PC=0x1000, memory with 1-cycle latency, inst_ready=1 -> requests to 0x1000, 0x1004, 0x1008...; inst_valid first high 2 cycles after the first accept; pc_out sequence 0x1000, 0x1004, 0x1008 with the matching words.
- inst_ready=0 for 10 cycles -> at most FIFO_DEPTH requests outstanding plus buffered; imem_req_valid drops; on release, no word is lost or duplicated and PCs are contiguous.
- Redirect to 0x2002 with 2 requests in flight -> both stale responses dropped; next request address 0x2000; first inst_valid carries pc_out=0x2000.
- Redirect in the same cycle as a response and a decode pop -> that response is discarded; the popped head is counted as consumed; the FIFO is empty the next cycle.
- imem_req_ready held low for 5 cycles -> imem_req_addr is stable; pc_q does not advance; inst_data=0x00000013 while empty.
- Reset asserted with 2 requests in flight, then responses arrive after deassert -> the responses are ignored; the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_zero_fetch.sv
// riscv_zero instruction fetch: in-order imem requests, small registered
// instruction buffer toward decode, redirect flush with stale-response drop.
module riscv_zero_fetch #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 2,
    parameter int          CNT_W      = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [63:0] pc_out
);
    localparam int             PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [31:0]    NOP     = 32'h00000013;

    logic [63:0]                 pc_q, pc_d;
    logic [63:0]                 resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [CNT_W-1:0]            infl_q, infl_d;
    logic [CNT_W-1:0]            drop_q, drop_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH-1:0][31:0] data_q;
    logic [FIFO_DEPTH-1:0][63:0] fpc_q;

    logic           req_fire, resp_ok, push, pop;
    logic [CNT_W:0] occ;

    // Buffered plus outstanding never exceeds the buffer, so every response has a slot.
    assign occ            = {1'b0, cnt_q} + {1'b0, infl_q};
    assign imem_req_valid = !reset && (occ < DEPTH_C) && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding (e.g. one orphaned by reset) is ignored.
    assign resp_ok = imem_resp_valid && (infl_q != '0);
    assign push    = resp_ok && (drop_q == '0) && !redirect_valid;

    assign inst_valid = (cnt_q != '0);
    assign pop        = inst_valid && inst_ready;
    assign inst_data  = inst_valid ? data_q[rd_ptr_q] : NOP;
    assign pc_out     = inst_valid ? fpc_q[rd_ptr_q] : 64'h0;

    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        cnt_d     = cnt_q;
        drop_d    = drop_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        infl_d    = infl_q + CNT_W'(req_fire) - CNT_W'(resp_ok);
        if (req_fire) begin
            pc_d = pc_q + 64'd4;
        end
        if (redirect_valid) begin
            // No request fires this cycle, so everything still outstanding is stale.
            pc_d      = {redirect_pc[63:2], 2'b00};
            resp_pc_d = {redirect_pc[63:2], 2'b00};
            cnt_d     = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            drop_d    = infl_d;
        end else begin
            if (resp_ok && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 64'd4;
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            cnt_q     <= '0;
            infl_q    <= '0;
            drop_q    <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            cnt_q     <= cnt_d;
            infl_q    <= infl_d;
            drop_q    <= drop_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    // Payload storage needs no reset; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= imem_resp_data;
            fpc_q[wr_ptr_q]  <= resp_pc_q;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(push && ({1'b0, cnt_q} == DEPTH_C)))
                else $error("riscv_zero_fetch: push into full instruction buffer");
        end
    end

endmodule
